// File: rtl/imem_loader.sv
// imem_loader: host-side IMEM port-A writer. Parses a framed byte stream
//   (MAGIC, CNT_LO, CNT_HI, 4*CNT data bytes LSB-first, CSUM) into 32-bit words
//   written to IMEM from word 0 upward, and holds the core in reset until the
//   image checksum verifies. Every output is registered; rx_ready never stalls.
// Ports: clk/rst (sync, active-high); rx_valid/rx_data/rx_ready byte stream;
//   imem_ena/imem_wea/imem_addra/imem_dina IMEM port A; core_rst core reset;
//   done image verified; err last frame rejected; words_loaded words written.
module imem_loader #(
    parameter int         ADDR_W = 14,
    parameter logic [7:0] MAGIC  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_ena,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              core_rst,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_LO = 3'd1;
    localparam logic [2:0] S_CNT_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // Largest legal word count; 33 bits so the shift cannot overflow.
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

    logic [2:0]        state_q,    state_d;
    logic              rx_ready_q, rx_ready_d;
    logic              ena_q,      ena_d;
    logic [3:0]        wea_q,      wea_d;
    logic [ADDR_W-1:0] addra_q,    addra_d;
    logic [31:0]       dina_q,     dina_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q,     done_d;
    logic              err_q,      err_d;
    logic [ADDR_W:0]   wl_q,       wl_d;
    logic [7:0]        csum_q,     csum_d;
    logic [7:0]        cnt_lo_q,   cnt_lo_d;
    logic [15:0]       cnt_q,      cnt_d;
    logic [1:0]        bidx_q,     bidx_d;
    logic [23:0]       wbuf_q,     wbuf_d;   // bytes 0..2 of the word in flight
    logic [ADDR_W-1:0] waddr_q,    waddr_d;

    logic        fire;
    logic [15:0] cnt_full;

    assign fire     = rx_valid & rx_ready_q;
    assign cnt_full = {rx_data, cnt_lo_q};

    always_comb begin
        state_d    = state_q;
        rx_ready_d = 1'b1;
        ena_d      = 1'b0;
        wea_d      = 4'h0;
        addra_d    = addra_q;
        dina_d     = dina_q;
        core_rst_d = core_rst_q;
        done_d     = done_q;
        err_d      = err_q;
        wl_d       = wl_q;
        csum_d     = csum_q;
        cnt_lo_d   = cnt_lo_q;
        cnt_d      = cnt_q;
        bidx_d     = bidx_q;
        wbuf_d     = wbuf_q;
        waddr_d    = waddr_q;

        case (state_q)
            S_IDLE: begin
                if (fire && rx_data == MAGIC) begin
                    csum_d  = 8'h00;
                    state_d = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (fire) begin
                    cnt_lo_d = rx_data;
                    csum_d   = csum_q + rx_data;
                    state_d  = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (fire) begin
                    cnt_d  = cnt_full;
                    csum_d = csum_q + rx_data;
                    if ({17'd0, cnt_full} > MAX_WORDS) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (cnt_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        bidx_d  = 2'd0;
                        waddr_d = '0;
                        wl_d    = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (fire) begin
                    csum_d = csum_q + rx_data;
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: wbuf_d[7:0]   = rx_data;
                        2'd1: wbuf_d[15:8]  = rx_data;
                        2'd2: wbuf_d[23:16] = rx_data;
                        default: begin
                            // Fourth byte completes the word: write it this edge.
                            ena_d   = 1'b1;
                            wea_d   = 4'hF;
                            addra_d = waddr_q;
                            dina_d  = {rx_data, wbuf_q};
                            waddr_d = waddr_q + ADDR_W'(1);
                            wl_d    = wl_q + (ADDR_W+1)'(1);
                            if (32'(wl_q) + 32'd1 == 32'(cnt_q)) begin
                                state_d = S_CSUM;
                            end
                        end
                    endcase
                end
            end
            S_CSUM: begin
                if (fire) begin
                    if (rx_data == csum_q) begin
                        core_rst_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_DONE: begin
                // A new MAGIC reloads: the core goes back into reset first.
                if (fire && rx_data == MAGIC) begin
                    core_rst_d = 1'b1;
                    done_d     = 1'b0;
                    csum_d     = 8'h00;
                    state_d    = S_CNT_LO;
                end
            end
            S_ERR: begin
                if (fire && rx_data == MAGIC) begin
                    err_d   = 1'b0;
                    csum_d  = 8'h00;
                    state_d = S_CNT_LO;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_ready_q <= 1'b0;
            ena_q      <= 1'b0;
            wea_q      <= 4'h0;
            addra_q    <= '0;
            dina_q     <= 32'h0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            wl_q       <= '0;
            csum_q     <= 8'h00;
            cnt_lo_q   <= 8'h00;
            cnt_q      <= 16'h0;
            bidx_q     <= 2'd0;
            wbuf_q     <= 24'h0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            rx_ready_q <= rx_ready_d;
            ena_q      <= ena_d;
            wea_q      <= wea_d;
            addra_q    <= addra_d;
            dina_q     <= dina_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
            wl_q       <= wl_d;
            csum_q     <= csum_d;
            cnt_lo_q   <= cnt_lo_d;
            cnt_q      <= cnt_d;
            bidx_q     <= bidx_d;
            wbuf_q     <= wbuf_d;
            waddr_q    <= waddr_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_ena     = ena_q;
    assign imem_wea     = wea_q;
    assign imem_addra   = addra_q;
    assign imem_dina    = dina_q;
    assign core_rst     = core_rst_q;
    assign done         = done_q;
    assign err          = err_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: drives framed byte streams (directed and random) into
//   imem_loader and compares IMEM writes and status against a reference model
//   that re-parses the whole byte history since the last reset.
module tb_imem_loader;

    localparam int AW = 14;

    logic          clk;
    logic          rst;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic          imem_ena;
    logic [3:0]    imem_wea;
    logic [AW-1:0] imem_addra;
    logic [31:0]   imem_dina;
    logic          core_rst;
    logic          done;
    logic          err;
    logic [AW:0]   words_loaded;

    imem_loader #(.ADDR_W(AW), .MAGIC(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .imem_ena     (imem_ena),
        .imem_wea     (imem_wea),
        .imem_addra   (imem_addra),
        .imem_dina    (imem_dina),
        .core_rst     (core_rst),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0]  hist[$];                 // accepted bytes since last reset
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          obs_addr[$];
    logic [31:0] obs_data[$];
    logic [3:0]  obs_wea[$];
    bit          exp_done, exp_err;
    int          exp_wl;

    always @(negedge clk) begin
        if (imem_ena === 1'b1) begin
            obs_addr.push_back(int'(imem_addra));
            obs_data.push_back(imem_dina);
            obs_wea.push_back(imem_wea);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the history frame by frame using the frame rules.
    task automatic predict();
        int n, i, j, k, cnt;
        logic [7:0]  s;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 0;
        exp_wl   = 0;
        n = hist.size();
        i = 0;
        while (i < n) begin
            if (hist[i] != 8'hA5) begin
                i++;
                continue;
            end
            exp_done = 0;
            exp_err  = 0;
            if (i + 2 >= n) return;
            cnt = int'(hist[i+1]) + 256 * int'(hist[i+2]);
            s   = hist[i+1] + hist[i+2];
            if (cnt > (1 << AW)) begin
                exp_err = 1;
                i += 3;
                continue;
            end
            if (cnt != 0) exp_wl = 0;
            j = i + 3;
            for (int wi = 0; wi < cnt; wi++) begin
                if (j + 4*wi + 3 >= n) return;
                w = {hist[j+4*wi+3], hist[j+4*wi+2], hist[j+4*wi+1], hist[j+4*wi]};
                s = s + w[7:0] + w[15:8] + w[23:16] + w[31:24];
                exp_addr.push_back(wi);
                exp_data.push_back(w);
                exp_wl = wi + 1;
            end
            k = j + 4*cnt;
            if (k >= n) return;
            if (hist[k] == s) exp_done = 1;
            else              exp_err  = 1;
            i = k + 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = $urandom_range(gap, 0);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        chk("rx_ready", rx_ready, 1);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        hist.push_back(b);
    endtask

    task automatic send_q(input logic [7:0] q[$], input int gap);
        foreach (q[i]) send_byte(q[i], gap);
    endtask

    // Status is checked one cycle after the last accepted byte; writes after
    // the monitor has seen the following falling edge.
    task automatic check_state(input string tag);
        predict();
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_core_rst"}, core_rst, !exp_done);
        chk({tag, "_wl"}, words_loaded, exp_wl);
        @(negedge clk);
        #1;
        chk({tag, "_nwr"}, obs_addr.size(), exp_addr.size());
        for (int i = 0; i < obs_addr.size() && i < exp_addr.size(); i++) begin
            chk({tag, "_addr"}, obs_addr[i], exp_addr[i]);
            chk({tag, "_data"}, obs_data[i], exp_data[i]);
            chk({tag, "_wea"}, obs_wea[i], 4'hF);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_rx_ready"}, rx_ready, 0);
        chk({tag, "_ena"}, imem_ena, 0);
        chk({tag, "_wea"}, imem_wea, 0);
        chk({tag, "_addra"}, imem_addra, 0);
        chk({tag, "_dina"}, imem_dina, 0);
        chk({tag, "_core_rst"}, core_rst, 1);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_wl"}, words_loaded, 0);
    endtask

    task automatic clear_hist();
        hist.delete();
        obs_addr.delete();
        obs_data.delete();
        obs_wea.delete();
    endtask

    logic [7:0] basic[$];
    logic [7:0] fr[$];

    initial begin
        logic [7:0]  s, b;
        int          cnt, nj;
        logic [31:0] w;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic load, no gaps, with hand-computed expectations as well.
        basic = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'hB8};
        send_q(basic, 0);
        chk("basic_done", done, 1);
        chk("basic_core_rst", core_rst, 0);
        chk("basic_wl", words_loaded, 2);
        check_state("basic");
        chk("basic_addr0", obs_addr[0], 0);
        chk("basic_data0", obs_data[0], 32'h0000_0013);
        chk("basic_addr1", obs_addr[1], 1);
        chk("basic_data1", obs_data[1], 32'h0010_0093);

        // Bad checksum: writes still happen, err raised.
        fr = basic;
        fr[11] = 8'hB7;
        send_q(fr, 0);
        chk("badcs_err", err, 1);
        check_state("badcs");

        // Junk ahead of a good frame, with random valid gaps; clears err.
        fr = {8'h00, 8'hFF, 8'h12};
        send_q(fr, 0);
        check_state("junk");
        send_q(basic, 3);
        check_state("gaps");

        // Reload from DONE: one MAGIC puts the core back into reset.
        send_byte(8'hA5, 0);
        chk("reload_core_rst", core_rst, 1);
        check_state("reload");
        fr = {8'h00, 8'h00, 8'h00};
        send_q(fr, 0);
        check_state("zero_len");

        // Oversize count rejected straight after CNT_HI.
        fr = {8'hA5, 8'h01, 8'h40};
        send_q(fr, 0);
        chk("oversize_err", err, 1);
        check_state("oversize");

        // Random frames: lengths, contents, bad checksums, oversize, gaps.
        for (int it = 0; it < 16; it++) begin
            fr.delete();
            nj = $urandom_range(2, 0);
            for (int j = 0; j < nj; j++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h00;
                fr.push_back(b);
            end
            fr.push_back(8'hA5);
            if ($urandom_range(7, 0) == 0) begin
                cnt = $urandom_range(65535, (1 << AW) + 1);
                fr.push_back(8'(cnt));
                fr.push_back(8'(cnt >> 8));
            end else begin
                cnt = $urandom_range(6, 0);
                fr.push_back(8'(cnt));
                fr.push_back(8'(cnt >> 8));
                s = 8'(cnt) + 8'(cnt >> 8);
                for (int wi = 0; wi < cnt; wi++) begin
                    w = $urandom;
                    if ($urandom_range(3, 0) == 0) w[15:8] = 8'hA5;
                    for (int bi = 0; bi < 4; bi++) begin
                        b = w[8*bi +: 8];
                        fr.push_back(b);
                        s = s + b;
                    end
                end
                if ($urandom_range(3, 0) == 0) s = s + 8'd1;
                fr.push_back(s);
            end
            send_q(fr, 2);
            check_state("rand");
        end

        // Reset after 6 data bytes: partial word dropped, no further writes.
        clear_hist();
        fr = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        send_q(fr, 1);
        check_state("partial");
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("mid_rst");
        clear_hist();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        fr = {8'h10, 8'h00};
        send_q(fr, 0);
        check_state("post_rst");
        send_q(basic, 2);
        check_state("post_rst_load");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Host-side writer for the instruction memory's write port (port A: ena/wea/addra/dina). The core only ever reads through port B.
- Takes a byte stream (valid/ready) carrying a framed program image and assembles little-endian 32-bit words, writing them to IMEM from address 0 upward.
- Holds the core in reset (core_rst) until an image is loaded and its checksum verifies.

Parameters:
- ADDR_W, 14, IMEM word-address width; the image may hold at most 2**ADDR_W words.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- rx_valid  input  1  byte-stream valid
- rx_data  input  8  byte-stream data
- rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid & rx_ready
- imem_ena  output  1  IMEM port A enable
- imem_wea  output  4  IMEM port A byte write enables
- imem_addra  output  ADDR_W  IMEM port A word address
- imem_dina  output  32  IMEM port A write data
- core_rst  output  1  reset to the core; high while no verified image is present
- done  output  1  a verified image is loaded
- err  output  1  the last frame was rejected
- words_loaded  output  ADDR_W+1  count of words written in the current frame

Behaviour:
- Clock, reset: clk; rst is synchronous, active-high. On reset:
  - state=IDLE, rx_ready=0, imem_ena=0, imem_wea=0, imem_addra=0, imem_dina=0
  - core_rst=1, done=0, err=0, words_loaded=0, checksum accumulator=0
- rx_ready=1 in every cycle after reset. No back-pressure.
- All outputs are registered.
- Frame format, in byte order: MAGIC, CNT_LO, CNT_HI, then 4*CNT data bytes (each word LSB first), then CSUM.
  - CNT is 16-bit.
  - CSUM = 8-bit sum, mod 256, of CNT_LO, CNT_HI and all data bytes.
- FSM states: IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERR.
  - IDLE: MAGIC -> CNT_LO and clear the accumulator. Any other byte is discarded.
  - CNT_LO: latch the byte and add it to the checksum -> CNT_HI.
  - CNT_HI: latch the byte and add it to the checksum.
    - CNT > 2**ADDR_W -> ERR.
    - CNT == 0 -> CSUM.
    - Otherwise -> DATA, with byte index 0, word address 0 and words_loaded=0.
  - DATA: shift each byte into the word buffer at lane = byte index and add it to the checksum.
    - On the 4th byte of a word: at that same clock edge, register imem_ena=1, imem_wea=4'hF, imem_addra=current word address, imem_dina={b3,b2,b1,b0}. These are valid for exactly one cycle, then return to ena=0, wea=0. addra and dina hold their last value.
    - After the write, increment the word address and words_loaded.
    - When words_loaded reaches CNT -> CSUM.
  - CSUM: a byte matching the accumulator -> DONE; a mismatch -> ERR.
  - DONE: core_rst=0 and done=1, both from the cycle after the CSUM byte is accepted. A MAGIC byte starts a reload: core_rst=1 and done=0 from the next cycle, -> CNT_LO. Other bytes are discarded.
  - ERR: err=1, core_rst=1, done=0. A MAGIC byte -> CNT_LO and clears err from the next cycle. Other bytes are discarded.
- core_rst stays 1 in every state except DONE.
- A MAGIC value received inside CNT_LO/CNT_HI/DATA/CSUM is treated as ordinary data. There is no resynchronisation mid-frame.
- Partial image on error: words already written stay in IMEM. The core is not released.
- Word address wrap is impossible: the CNT bound guarantees it; the last address written is CNT-1.
- rst mid-frame: abort immediately and apply the reset values. No further IMEM writes occur. Any partial word is dropped.
- rx_valid=0 cycles inside a frame simply stall progress. There is no timeout.

Test Plan:
- Basic load: after reset, send A5 02 00 | 13 00 00 00 | 93 00 10 00 | CSUM=0xB8.
  - Two ena pulses with wea=F: addr 0 / data 0x00000013, then addr 1 / data 0x00100093.
  - done=1 and core_rst=0 from the cycle after CSUM; words_loaded=2.
- Bad checksum: same frame with CSUM=0xB7.
  - Two writes occur; err=1, core_rst=1, done=0.
  - A new valid frame clears err and ends in done=1.
- Zero-length and oversize:
  - A5 00 00 00 -> no ena pulse, done=1.
  - A5 01 40 (CNT=0x4001, ADDR_W=14) -> ERR right after CNT_HI, no writes.
- Gaps and junk: leading bytes 00 FF 12 before A5 are ignored. Random rx_valid gaps inside the Basic-load frame give identical writes and result.
- Reload and reset mid-frame:
  - In DONE, send A5 -> core_rst=1 and done=0 next cycle.
  - Assert rst after 6 data bytes -> no further writes, all outputs at reset values, the next full frame loads correctly.
